ntt_writeback_ctrl: RTL and testbench
=====================================

// Module: ntt_writeback_ctrl
// PURPOSE
//  Write-side counterpart of the NTT read/address controller: tracks each issued read through the butterfly pipeline.
//  Regenerates the in-place write address, write strobe and stage tag for the coefficient memory.
//  Counts writes per stage and reports per-stage and whole-transform completion.
//  Sits between the read controller outputs and the memory write port, in parallel with the NTT core array.
// PARAMETERS
//  LOG_RING_SIZE  12  log2 of polynomial ring size
//  LOG_NTT_CORE   4   log2 of number of butterfly cores
//  BF_LATENCY     10  read-to-write pipeline depth in cycles; legal range 1..15, below the 16-cycle inter-stage wait
//  ADDR_W  (local)    LOG_RING_SIZE-LOG_NTT_CORE-1
//  N_LOOP  (local)    2**ADDR_W, the number of writes per stage
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       asynchronous, active-low reset
//  start      in   1       one-cycle pulse at start of a transform, same cycle as the read controller start
//  rd_en      in   1       read issued this cycle (read controller write-enable output)
//  rd_addr    in   ADDR_W  row address of that read
//  rd_stage   in   5       NTT stage of that read
//  wr_en      out  1       memory write strobe
//  wr_addr    out  ADDR_W  write row address, in place: equals the delayed rd_addr
//  wr_stage   out  5       stage tag of the current write
//  stage_done out  1       1-cycle pulse after the N_LOOP-th write of a stage
//  all_done   out  1       1-cycle pulse coincident with stage_done of stage LOG_RING_SIZE-1
//  err        out  1       sticky protocol error flag, cleared by start or reset
// BEHAVIOUR
//  Reset (reset=0, async): every output 0; delay line valid bits, counters and FSM cleared; FSM goes to IDLE.
//  Delay line: BF_LATENCY entries of {valid, addr, stage}, shifting every cycle.
//   - {rd_en, rd_addr, rd_stage} sampled in cycle t appear on {wr_en, wr_addr, wr_stage} in cycle t+BF_LATENCY.
//   - wr_addr and wr_stage hold their last value while wr_en=0.
//  FSM, states IDLE, RUN and DRAIN:
//   - IDLE->RUN on start.
//   - RUN->DRAIN when the stage-(LOG_RING_SIZE-1) write count reaches N_LOOP.
//   - DRAIN->IDLE one cycle later, once the delay line is empty.
//   - rd_en seen in IDLE: ignored, err<=1.
//  Write counter wcnt, ADDR_W+1 bits:
//   - increments on each wr_en.
//   - on the write that makes wcnt=N_LOOP: stage_done pulses next cycle, wcnt<=0, expected stage exp_stg<=exp_stg+1.
//  Checks, each sets err<=1 and changes nothing else:
//   - wr_en with wr_stage!=exp_stg.
//   - rd_stage changes while a read of the previous stage is still in the delay line, i.e. the inter-stage wait was too short.
//  all_done: pulses with stage_done when exp_stg=LOG_RING_SIZE-1; exp_stg then wraps to 0.
//  Simultaneous events:
//   - start while RUN/DRAIN: abort. Delay line flushed to valid=0, wcnt=0, exp_stg=0, err=0.
//   - No stage_done or all_done is emitted for the aborted transform; FSM goes to RUN.
//   - start and rd_en in the same cycle: that read is captured into the new transform.
//  Back-to-back transforms: start is legal in the cycle after all_done.
//  Widths: rd_stage and wr_stage are unsigned 5-bit; wcnt never exceeds N_LOOP.
// TESTING
//  1) Defaults; start, then rd_en=1 for 128 cycles with addr 0..127, stage 0 -> wr_en high on cycles 10..137 with addr 0..127; stage_done=1 at cycle 138.
//  2) Full 12-stage run with 16-cycle waits -> 12 stage_done pulses; all_done only with the 12th; err stays 0; FSM returns to IDLE.
//  3) rd_en=1 while IDLE, before any start -> wr_en stays 0, err=1; the next start clears err.
//  4) start pulsed mid-stage 3 with 60 writes done -> no stage_done; the next 128 stage-0 reads complete normally.
//  5) Stage-1 reads begin 5 cycles after the last stage-0 read with BF_LATENCY=10 -> err=1.
//  6) reset asserted mid-RUN, then released -> all outputs 0 asynchronously; no wr_en until a new start.

Source files
------------

// File: rtl/ntt_writeback_ctrl.sv
// ntt_writeback_ctrl: delays issued reads by the butterfly latency into in-place writes
// and tracks per-stage and whole-transform write completion.
module ntt_writeback_ctrl #(
  parameter int LOG_RING_SIZE = 12,
  parameter int LOG_NTT_CORE  = 4,
  parameter int BF_LATENCY    = 10
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  rd_en,
  input  logic [LOG_RING_SIZE-LOG_NTT_CORE-2:0] rd_addr,
  input  logic [4:0]                            rd_stage,
  output logic                                  wr_en,
  output logic [LOG_RING_SIZE-LOG_NTT_CORE-2:0] wr_addr,
  output logic [4:0]                            wr_stage,
  output logic                                  stage_done,
  output logic                                  all_done,
  output logic                                  err
);
  localparam int ADDR_W = LOG_RING_SIZE - LOG_NTT_CORE - 1;
  localparam int N_LOOP = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(N_LOOP - 1);
  localparam logic [4:0] LAST_STG = 5'(LOG_RING_SIZE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [BF_LATENCY-1:0] dv, nv;
  logic [ADDR_W-1:0] da [BF_LATENCY];
  logic [4:0] ds [BF_LATENCY];
  logic [ADDR_W:0] wcnt;
  logic [4:0] exp_stg;
  logic cap, mix, stg_ok, wdone, last;
  assign wr_en    = dv[BF_LATENCY-1];
  assign wr_addr  = da[BF_LATENCY-1];
  assign wr_stage = ds[BF_LATENCY-1];
  assign cap      = rd_en && (state != IDLE || start);
  assign nv       = BF_LATENCY'({dv, cap});
  assign stg_ok   = wr_stage == exp_stg;
  assign wdone    = wr_en && stg_ok && wcnt == LAST_CNT;
  assign last     = exp_stg == LAST_STG;
  // any in-flight read tagged with a different stage means the inter-stage gap was too short
  always_comb begin
    mix = 1'b0;
    for (int i = 0; i < BF_LATENCY; i++) mix = mix | (dv[i] && ds[i] != rd_stage);
  end
  always_comb begin
    state_n = start ? RUN :
              (state == RUN && wdone && last) ? DRAIN :
              (state == DRAIN && !(|dv)) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dv         <= '0;
      wcnt       <= '0;
      exp_stg    <= '0;
      stage_done <= 1'b0;
      all_done   <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < BF_LATENCY; i++) begin
        da[i] <= '0;
        ds[i] <= '0;
      end
    end else begin
      dv         <= start ? BF_LATENCY'(cap) : nv;
      stage_done <= !start && wdone;
      all_done   <= !start && wdone && last;
      err        <= start ? 1'b0 : err | (rd_en && state == IDLE) | (rd_en && mix) | (wr_en && !stg_ok);
      // the output entry only loads on a valid write so wr_addr/wr_stage hold between writes
      for (int i = 0; i < BF_LATENCY; i++)
        if (i < BF_LATENCY-1 || (nv[i] && (i == 0 || !start))) begin
          da[i] <= (i == 0) ? rd_addr : da[i == 0 ? 0 : i-1];
          ds[i] <= (i == 0) ? rd_stage : ds[i == 0 ? 0 : i-1];
        end
      if (start) begin
        wcnt    <= '0;
        exp_stg <= '0;
      end else if (wr_en && stg_ok) begin
        wcnt    <= wdone ? '0 : wcnt + 1'b1;
        exp_stg <= wdone ? (last ? '0 : exp_stg + 1'b1) : exp_stg;
      end
    end
endmodule

// File: tb/tb_ntt_writeback_ctrl.sv
// tb_ntt_writeback_ctrl: randomized scenarios checked cycle by cycle against a queue-based model.
module tb_ntt_writeback_ctrl;
  localparam int L = 10, AW = 7, NL = 128, NS = 12;
  logic clk = 0, reset = 1, start = 0, rd_en = 0;
  logic [AW-1:0] rd_addr = 0;
  logic [4:0] rd_stage = 0;
  logic wr_en, stage_done, all_done, err;
  logic [AW-1:0] wr_addr;
  logic [4:0] wr_stage;
  int checks = 0, errors = 0;
  logic [15:0] obs[$], expq[$];

  typedef struct {int due; int a; int s;} rd_t;
  rd_t pend[$];
  int e = 0, wcnt, estg, m_wa, m_ws;
  bit busy, drain, m_wen, m_sd, m_ad, m_err;

  ntt_writeback_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_stage(rd_stage), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stage(wr_stage),
    .stage_done(stage_done), .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] dut_word();
    return {wr_en, wr_addr, wr_stage, stage_done, all_done, err};
  endfunction

  function automatic logic [15:0] model_word();
    return {m_wen, 7'(m_wa), 5'(m_ws), m_sd, m_ad, m_err};
  endfunction

  task automatic model_reset();
    pend.delete();
    busy = 0; drain = 0; wcnt = 0; estg = 0;
    m_wen = 0; m_sd = 0; m_ad = 0; m_err = 0; m_wa = 0; m_ws = 0;
  endtask

  // A read issued at edge e is written L cycles after its issue cycle; writes are counted per stage.
  task automatic model_edge(input bit st, input bit re, input int ra, input int rs);
    bit mix = 0, empty, sbad, was_busy, was_run;
    foreach (pend[i]) if (pend[i].s != rs) mix = 1;
    if (m_wen && m_ws != rs) mix = 1;
    empty = pend.size() == 0 && !m_wen;
    sbad = m_wen && m_ws != estg;
    was_busy = busy;
    was_run = busy && !drain;
    e++;
    m_sd = 0; m_ad = 0;
    if (st) begin
      pend.delete();
      if (re) pend.push_back('{e + L - 1, ra, rs});
      wcnt = 0; estg = 0; m_err = 0; busy = 1; drain = 0;
    end else begin
      if ((re && !was_busy) || (re && mix) || sbad) m_err = 1;
      if (re && was_busy) pend.push_back('{e + L - 1, ra, rs});
      if (drain && empty) begin busy = 0; drain = 0; end
      if (m_wen && !sbad) begin
        wcnt++;
        if (wcnt == NL) begin
          wcnt = 0; m_sd = 1; m_ad = (estg == NS - 1);
          if (m_ad && was_run) drain = 1;
          estg = m_ad ? 0 : estg + 1;
        end
      end
    end
    if (pend.size() > 0 && pend[0].due == e) begin
      m_wen = 1; m_wa = pend[0].a; m_ws = pend[0].s;
      void'(pend.pop_front());
    end else m_wen = 0;
  endtask

  task automatic tick(input bit st, input bit re, input int ra, input int rs);
    @(negedge clk);
    start = st; rd_en = re; rd_addr = AW'(ra); rd_stage = 5'(rs);
    @(posedge clk);
    model_edge(st, re, ra, rs);
    #1;
    obs.push_back(dut_word());
    expq.push_back(model_word());
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, $urandom_range(0, NL-1), $urandom_range(0, 31));
  endtask

  task automatic issue_reads(input bit st_first, input int s, input int n);
    for (int i = 0; i < n; i++) tick(st_first && i == 0, 1, $urandom_range(0, NL-1), s);
  endtask

  task automatic trace_clear();
    obs.delete();
    expq.delete();
  endtask

  task automatic test_reset();
    #2 reset = 0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (dut_word() !== 16'h0) begin
        errors++; $display("FAIL reset outputs: got %h expected 0000", dut_word());
      end
    end
    @(negedge clk) reset = 1;
  endtask

  task automatic test_idle_read();
    trace_clear();
    for (int i = 0; i < 5; i++) tick(0, 1, $urandom_range(0, NL-1), 0);
    idle_ticks(15);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL idle_read err: got %b expected 1", err); end
    tick(1, 0, 0, 0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL idle_read start clears err: got %b expected 0", err); end
    idle_ticks(2);
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== expq[i]) begin errors++; $display("FAIL idle_read cycle %0d: got %h expected %h", i, obs[i], expq[i]); end
    end
  endtask

  task automatic test_single_stage();
    int first = -1, nw = 0, sd_at = -1;
    trace_clear();
    for (int i = 0; i < NL; i++) tick(i == 0, 1, i, 0);
    idle_ticks(20);
    foreach (obs[i]) begin
      if (obs[i][15]) begin nw++; if (first < 0) first = i; end
      if (obs[i][2] && sd_at < 0) sd_at = i;
    end
    checks++;
    if (first != L - 1) begin errors++; $display("FAIL single first write index: got %0d expected %0d", first, L - 1); end
    checks++;
    if (nw != NL) begin errors++; $display("FAIL single write count: got %0d expected %0d", nw, NL); end
    checks++;
    if (sd_at != NL + L - 1) begin errors++; $display("FAIL single stage_done index: got %0d expected %0d", sd_at, NL + L - 1); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== expq[i]) begin errors++; $display("FAIL single cycle %0d: got %h expected %h", i, obs[i], expq[i]); end
    end
  endtask

  task automatic test_full_transform();
    int nsd = 0, nad = 0, bad_ad = 0, nerr = 0;
    trace_clear();
    issue_reads(1, 0, NL);
    for (int s = 1; s < NS; s++) begin idle_ticks(16); issue_reads(0, s, NL); end
    idle_ticks(20);
    foreach (obs[i]) begin
      nsd += obs[i][2]; nad += obs[i][1]; nerr += obs[i][0];
      if (obs[i][1] && !obs[i][2]) bad_ad++;
    end
    checks++;
    if (nsd != NS) begin errors++; $display("FAIL full stage_done count: got %0d expected %0d", nsd, NS); end
    checks++;
    if (nad != 1 || bad_ad != 0) begin errors++; $display("FAIL full all_done: got %0d pulses (%0d misaligned) expected 1", nad, bad_ad); end
    checks++;
    if (nerr != 0) begin errors++; $display("FAIL full err cycles: got %0d expected 0", nerr); end
    tick(0, 1, 3, 0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL full back to idle (read flags err): got %b expected 1", err); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== expq[i]) begin errors++; $display("FAIL full cycle %0d: got %h expected %h", i, obs[i], expq[i]); end
    end
  endtask

  task automatic test_abort();
    int nsd = 0, nad = 0;
    trace_clear();
    issue_reads(1, 0, NL);
    for (int s = 1; s < 3; s++) begin idle_ticks(16); issue_reads(0, s, NL); end
    idle_ticks(16);
    issue_reads(0, 3, 60);
    idle_ticks(12);
    issue_reads(1, 0, NL);
    idle_ticks(20);
    foreach (obs[i]) begin nsd += obs[i][2]; nad += obs[i][1]; end
    checks++;
    if (nsd != 4) begin errors++; $display("FAIL abort stage_done count: got %0d expected 4", nsd); end
    checks++;
    if (nad != 0 || err !== 1'b0) begin errors++; $display("FAIL abort all_done/err: got %0d/%b expected 0/0", nad, err); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== expq[i]) begin errors++; $display("FAIL abort cycle %0d: got %h expected %h", i, obs[i], expq[i]); end
    end
  endtask

  task automatic test_short_wait();
    trace_clear();
    issue_reads(1, 0, NL);
    idle_ticks(4);
    issue_reads(0, 1, NL);
    idle_ticks(20);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL short_wait err: got %b expected 1", err); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== expq[i]) begin errors++; $display("FAIL short_wait cycle %0d: got %h expected %h", i, obs[i], expq[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    int nw = 0;
    trace_clear();
    issue_reads(1, 0, 40);
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if (dut_word() !== 16'h0) begin errors++; $display("FAIL reset_mid_run async outputs: got %h expected 0000", dut_word()); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    trace_clear();
    for (int i = 0; i < 20; i++) tick(0, 1, $urandom_range(0, NL-1), 0);
    foreach (obs[i]) nw += obs[i][15];
    checks++;
    if (nw != 0) begin errors++; $display("FAIL reset_mid_run writes without start: got %0d expected 0", nw); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== expq[i]) begin errors++; $display("FAIL reset_mid_run cycle %0d: got %h expected %h", i, obs[i], expq[i]); end
    end
  endtask

  task automatic test_random();
    trace_clear();
    tick(1, 1, $urandom_range(0, NL-1), 0);
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, NL-1),
           $urandom_range(0, 7) == 0 ? 1 : 0);
    idle_ticks(20);
    foreach (obs[i]) begin
      checks++;
      if (obs[i] !== expq[i]) begin errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs[i], expq[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_read();
    test_single_stage();
    test_full_transform();
    test_abort();
    test_short_wait();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
